pipelined_carry_select_adder: RTL and testbench
===============================================

// Module: pipelined_carry_select_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder with valid/ready streaming handshake.
//  Operands are split into BLOCK-bit blocks:
//  - block 0 is a ripple-carry add with cin;
//  - every higher block precomputes sum/carry for carry-in 0 and 1, then muxes on the incoming carry.
//  A register stage follows every BLK_PER_STAGE blocks, so WIDTH scales without lengthening the critical path.
//  Sits in the arithmetic datapath; it is the drop-in streaming successor of the fixed 16-bit select adder.
// PARAMETERS
//  WIDTH          16  operand/sum width in bits; must be a multiple of BLOCK
//  BLOCK           4  bits per carry-select block
//  BLK_PER_STAGE   1  blocks resolved per pipeline stage; (WIDTH/BLOCK) must be a multiple of it
//  Derived: NUM_BLK = WIDTH/BLOCK; STAGES = NUM_BLK/BLK_PER_STAGE (pipeline depth, latency)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      adder accepts a/b/cin this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (only with CSA_OVERFLOW_EN)
// BEHAVIOUR
//  Reset: asserting rst_n low asynchronously clears every stage valid bit and all outputs.
//   - Outputs while in reset: out_valid=0, sum=0, cout=0, ovf=0.
//   - in_ready=1 from the first clock edge after release.
//  Stage s (0..STAGES-1) holds:
//   - valid_s;
//   - resolved carry c_s;
//   - sum bits [(s+1)*BLK_PER_STAGE*BLOCK-1:0] computed so far;
//   - the unconsumed upper a/b bits.
//  Stage 0 takes a/b/cin on an in_valid && in_ready transfer.
//  Inside each stage:
//   - each block muxes its precomputed (sum0,c0)/(sum1,c1) pair on the carry from the block below;
//   - the carry chains through BLK_PER_STAGE muxes per stage.
//  Advance rule: stage s loads from s-1 when !valid_s || advance_(s+1).
//   - Last stage advance = out_ready.
//   - in_ready = !valid_0 || advance_1. This is a combinational ready chain; there is no skid buffer.
//  Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure.
//   - Throughput: 1 result per cycle.
//  Ordering: results leave strictly in acceptance order; no loss and no duplication under any out_ready pattern.
//  Holding: while out_valid && !out_ready, sum/cout/ovf hold stable.
//  Full: when all STAGES are valid and out_ready=0, in_ready=0.
//  Simultaneous accept and drain on a full pipe is legal; occupancy is unchanged.
//  Width rule: {cout,sum} == a + b + cin computed at WIDTH+1 bits; wrap-around is modulo 2^WIDTH.
//  Bubbles: a stage with valid=0 may hold stale data; sum/cout are registered outputs of the last stage.
//  Reset mid-operation: all in-flight results are discarded; none appear after release.
//  Elaboration: illegal parameter divisibility triggers an elaboration-time $error.
// CONFIGURATION
//  CSA_OVERFLOW_EN defined:
//   - port ovf is present;
//   - ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]);
//   - the operand sign bits are carried through the pipe with the result, so ovf is aligned with sum.
//  CSA_OVERFLOW_EN undefined:
//   - port ovf and its sign-bit pipeline registers are absent;
//   - all other behaviour is identical.
// TESTING (defaults: WIDTH=16, BLOCK=4, BLK_PER_STAGE=1, STAGES=4)
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, cout=0. After release, in_ready=1.
//  2 Full carry propagate: a=FFFF, b=0001, cin=0, accepted at cycle 0 -> cycle 4: out_valid=1, sum=0000, cout=1.
//    Then a=1234, b=4321, cin=1 -> sum=5556, cout=0.
//  3 Streaming: 8 random operands on consecutive cycles, out_ready=1 -> 8 consecutive results in order.
//    Each matches a+b+cin; in_ready stays 1 throughout.
//  4 Backpressure: out_ready=0, offer 6 operands -> exactly 4 accepted, then in_ready=0 and the output holds the 1st result.
//    Raise out_ready -> the remaining results drain in order; none lost.
//  5 Reset mid-flight: 2 operands in flight, pulse rst_n low between clock edges -> out_valid drops immediately.
//    No result appears after release.
//  6 CSA_OVERFLOW_EN: a=7FFF, b=0001 -> sum=8000, ovf=1. a=8000, b=FFFF -> sum=7FFF, cout=1, ovf=1.
//    a=0001, b=0001 -> ovf=0.
//  Also run WIDTH=32, BLOCK=8, BLK_PER_STAGE=2 (latency 2) with a random-vs-reference scoreboard under random out_ready.

Source files
------------

// File: rtl/pipelined_carry_select_adder_if.sv
// Streaming valid/ready bundle for pipelined_carry_select_adder; ovf exists only when CSA_OVERFLOW_EN is defined.
interface pipelined_carry_select_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CSA_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CSA_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder, one register stage per BLK_PER_STAGE blocks, valid/ready on both sides.
// Define CSA_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_carry_select_adder #(
  parameter int WIDTH         = 16,
  parameter int BLOCK         = 4,
  parameter int BLK_PER_STAGE = 1
) (
  input logic                          clk,
  input logic                          rst_n,
  pipelined_carry_select_adder_if.slave link
);
  localparam int NUM_BLK = WIDTH / BLOCK;
  localparam int STAGES  = NUM_BLK / BLK_PER_STAGE;
  localparam int SPAN    = BLK_PER_STAGE * BLOCK;

  if ((WIDTH % BLOCK) != 0 || (NUM_BLK % BLK_PER_STAGE) != 0) begin : g_param_check
    $error("pipelined_carry_select_adder: WIDTH/BLOCK/BLK_PER_STAGE divisibility violated");
  end

  genvar gi, gk;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SPAN;
    localparam int RW = WIDTH - LO;

    logic                 src_valid;
    logic                 src_c;
    logic [RW-1:0]        src_a;
    logic [RW-1:0]        src_b;
    logic [SPAN-1:0]      part;
    logic [LO+SPAN-1:0]   sum_next;
    logic [LO+SPAN-1:0]   sum_reg;
    logic                 valid_reg;
    logic                 c_reg;
    logic                 load;

    if (gi == 0) begin : g_src
      assign src_valid = link.in_valid;
      assign src_c     = link.cin;
      assign src_a     = link.a;
      assign src_b     = link.b;
      assign sum_next  = part;
    end else begin : g_src
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_c     = g_stage[gi-1].c_reg;
      assign src_a     = g_stage[gi-1].g_fwd.a_reg;
      assign src_b     = g_stage[gi-1].g_fwd.b_reg;
      assign sum_next  = {part, g_stage[gi-1].sum_reg};
    end

    // Combinational ready chain: a stage may load if empty or if its contents move on this edge.
    if (gi == STAGES - 1) begin : g_load
      assign load = !valid_reg || link.out_ready;
    end else begin : g_load
      assign load = !valid_reg || g_stage[gi+1].load;
    end

    for (gk = 0; gk < BLK_PER_STAGE; gk++) begin : g_blk
      localparam int BO = gk * BLOCK;
      logic             c_in;
      logic             c_out;
      logic [BLOCK-1:0] s_out;

      if (gk == 0) begin : g_cin
        assign c_in = src_c;
      end else begin : g_cin
        assign c_in = g_blk[gk-1].c_out;
      end

      if (gi == 0 && gk == 0) begin : g_ripple
        assign {c_out, s_out} = {1'b0, src_a[BO +: BLOCK]} + {1'b0, src_b[BO +: BLOCK]}
                              + {{BLOCK{1'b0}}, c_in};
      end else begin : g_select
        logic [BLOCK:0] pre0;
        logic [BLOCK:0] pre1;
        assign pre0 = {1'b0, src_a[BO +: BLOCK]} + {1'b0, src_b[BO +: BLOCK]};
        assign pre1 = {1'b0, src_a[BO +: BLOCK]} + {1'b0, src_b[BO +: BLOCK]} + (BLOCK+1)'(1);
        assign {c_out, s_out} = c_in ? pre1 : pre0;
      end

      assign part[BO +: BLOCK] = s_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        c_reg     <= 1'b0;
        sum_reg   <= '0;
      end else if (load) begin
        valid_reg <= src_valid;
        c_reg     <= g_blk[BLK_PER_STAGE-1].c_out;
        sum_reg   <= sum_next;
      end
    end

    // Only the operand bits not yet consumed travel on to the next stage.
    if (gi < STAGES - 1) begin : g_fwd
      logic [RW-SPAN-1:0] a_reg;
      logic [RW-SPAN-1:0] b_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (load) begin
          a_reg <= src_a[RW-1:SPAN];
          b_reg <= src_b[RW-1:SPAN];
        end
      end
    end
  end

  assign link.in_ready  = g_stage[0].load;
  assign link.out_valid = g_stage[STAGES-1].valid_reg;
  assign link.sum       = g_stage[STAGES-1].sum_reg;
  assign link.cout      = g_stage[STAGES-1].c_reg;

`ifdef CSA_OVERFLOW_EN
  // Sign bits reach the last stage inside its operand slice, so ovf is registered alongside sum.
  logic ovf_reg;
  logic sign_a;
  logic sign_b;
  logic sign_s;
  assign sign_a = g_stage[STAGES-1].src_a[SPAN-1];
  assign sign_b = g_stage[STAGES-1].src_b[SPAN-1];
  assign sign_s = g_stage[STAGES-1].part[SPAN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (g_stage[STAGES-1].load) begin
      ovf_reg <= (sign_a == sign_b) && (sign_s != sign_a);
    end
  end

  assign link.ovf = ovf_reg;
`endif
endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed + scoreboard bench for pipelined_carry_select_adder (16/4/1 and 32/8/2 instances).
module tb_pipelined_carry_select_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_select_adder_if #(.WIDTH(16)) link16 ();
  pipelined_carry_select_adder_if #(.WIDTH(32)) link32 ();

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4), .BLK_PER_STAGE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .link(link16)
  );
  pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8), .BLK_PER_STAGE(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .link(link32)
  );

  int errors = 0;
  int checks = 0;
  logic [17:0] q16[$];
  logic [33:0] q32[$];
  logic [17:0] e16, o16;
  logic [33:0] e32, o32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + 17'(c);
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t};
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + 33'(c);
    o = (a[31] == b[31]) && (t[31] != a[31]);
    return {o, t};
  endfunction

  always @(negedge rst_n) begin
    q16.delete();
    q32.delete();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (link16.out_valid && link16.out_ready) begin
        check("sb16_nonempty", 64'(q16.size() > 0), 64'd1);
        if (q16.size() > 0) begin
          e16 = q16.pop_front();
`ifdef CSA_OVERFLOW_EN
          o16 = {link16.ovf, link16.cout, link16.sum};
`else
          o16 = {1'b0, link16.cout, link16.sum};
          e16[17] = 1'b0;
`endif
          check("sb16_result", 64'(o16), 64'(e16));
        end
      end
      if (link16.in_valid && link16.in_ready)
        q16.push_back(model16(link16.a, link16.b, link16.cin));
      if (link32.out_valid && link32.out_ready) begin
        check("sb32_nonempty", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e32 = q32.pop_front();
`ifdef CSA_OVERFLOW_EN
          o32 = {link32.ovf, link32.cout, link32.sum};
`else
          o32 = {1'b0, link32.cout, link32.sum};
          e32[33] = 1'b0;
`endif
          check("sb32_result", 64'(o32), 64'(e32));
        end
      end
      if (link32.in_valid && link32.in_ready)
        q32.push_back(model32(link32.a, link32.b, link32.cin));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, output int tries);
    logic fired;
    fired = 1'b0;
    tries = 0;
    link16.in_valid = 1'b1;
    link16.a = a;
    link16.b = b;
    link16.cin = c;
    while (!fired && tries < 64) begin
      @(negedge clk);
      fired = link16.in_ready;
      step();
      tries++;
    end
    link16.in_valid = 1'b0;
    check("send16_accepted", 64'(fired), 64'd1);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic rnd);
    logic fired;
    int   tries;
    fired = 1'b0;
    tries = 0;
    link32.in_valid = 1'b1;
    link32.a = a;
    link32.b = b;
    link32.cin = c;
    while (!fired && tries < 64) begin
      if (rnd) link32.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = link32.in_ready;
      step();
      tries++;
    end
    link32.in_valid = 1'b0;
    check("send32_accepted", 64'(fired), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    link16.out_ready = 1'b1;
    link32.out_ready = 1'b1;
    while ((q16.size() > 0 || q32.size() > 0) && n < 200) begin
      step();
      n++;
    end
    check("drain16_empty", 64'(q16.size()), 64'd0);
    check("drain32_empty", 64'(q32.size()), 64'd0);
  endtask

  initial begin
    int          tries;
    int          idx;
    int          n;
    logic        fire;
    logic        seen;
    logic [17:0] ex;
    logic [15:0] va[8];
    logic [15:0] vb[8];
    logic        vc[8];

    link16.in_valid = 1'b1;
    link16.a = 16'hABCD;
    link16.b = 16'h1111;
    link16.cin = 1'b1;
    link16.out_ready = 1'b1;
    link32.in_valid = 1'b0;
    link32.a = '0;
    link32.b = '0;
    link32.cin = 1'b0;
    link32.out_ready = 1'b1;

    // Reset held with in_valid asserted
    repeat (3) step();
    check("rst_out_valid", 64'(link16.out_valid), 64'd0);
    check("rst_sum", 64'(link16.sum), 64'd0);
    check("rst_cout", 64'(link16.cout), 64'd0);
`ifdef CSA_OVERFLOW_EN
    check("rst_ovf", 64'(link16.ovf), 64'd0);
`endif
    link16.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(link16.in_ready), 64'd1);
    check("rst_idle_valid", 64'(link16.out_valid), 64'd0);

    // Full carry propagate, exact latency
    send16(16'hFFFF, 16'h0001, 1'b0, tries);
    check("lat_edge1", 64'(link16.out_valid), 64'd0);
    step();
    check("lat_edge2", 64'(link16.out_valid), 64'd0);
    step();
    check("lat_edge3", 64'(link16.out_valid), 64'd0);
    step();
    check("lat_edge4_valid", 64'(link16.out_valid), 64'd1);
    check("carry_sum", 64'(link16.sum), 64'h0000);
    check("carry_cout", 64'(link16.cout), 64'd1);

    send16(16'h1234, 16'h4321, 1'b1, tries);
    n = 0;
    while (!link16.out_valid && n < 20) begin
      step();
      n++;
    end
    check("cin_valid", 64'(link16.out_valid), 64'd1);
    check("cin_sum", 64'(link16.sum), 64'h5556);
    check("cin_cout", 64'(link16.cout), 64'd0);
    drain();

    // Streaming, in_ready must stay high
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
      send16(va[i], vb[i], vc[i], tries);
      check("stream_first_try", 64'(tries), 64'd1);
    end
    drain();

    // Backpressure: fill, verify hold, then drain
    link16.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      link16.in_valid = (idx < 6);
      if (idx < 6) begin
        link16.a = va[idx];
        link16.b = vb[idx];
        link16.cin = vc[idx];
      end
      @(negedge clk);
      fire = link16.in_valid && link16.in_ready;
      step();
      if (fire) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd4);
    check("bp_in_ready", 64'(link16.in_ready), 64'd0);
    check("bp_out_valid", 64'(link16.out_valid), 64'd1);
    ex = model16(va[0], vb[0], vc[0]);
    check("bp_hold_result", 64'({link16.cout, link16.sum}), 64'(ex[16:0]));
    link16.out_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 64) begin
      link16.in_valid = 1'b1;
      link16.a = va[idx];
      link16.b = vb[idx];
      link16.cin = vc[idx];
      @(negedge clk);
      fire = link16.in_valid && link16.in_ready;
      step();
      if (fire) idx++;
      n++;
    end
    link16.in_valid = 1'b0;
    check("bp_rest_accepted", 64'(idx), 64'd6);
    drain();

    // Reset mid-flight
    link16.out_ready = 1'b0;
    send16(16'h0F0F, 16'h00F1, 1'b0, tries);
    send16(16'h7777, 16'h1111, 1'b1, tries);
    repeat (4) step();
    check("mid_valid_before", 64'(link16.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_drop", 64'(link16.out_valid), 64'd0);
    check("mid_sum_clear", 64'(link16.sum), 64'd0);
    #2;
    rst_n = 1'b1;
    link16.out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen = seen | link16.out_valid;
    end
    check("mid_no_ghost", 64'(seen), 64'd0);

`ifdef CSA_OVERFLOW_EN
    send16(16'h7FFF, 16'h0001, 1'b0, tries);
    send16(16'h8000, 16'hFFFF, 1'b0, tries);
    send16(16'h0001, 16'h0001, 1'b0, tries);
    drain();
`endif

    // 32-bit, 2-stage instance
    send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    check("lat32_edge1", 64'(link32.out_valid), 64'd0);
    step();
    check("lat32_edge2_valid", 64'(link32.out_valid), 64'd1);
    check("lat32_sum", 64'(link32.sum), 64'h0000_0001);
    check("lat32_cout", 64'(link32.cout), 64'd1);
    for (int i = 0; i < 150; i++)
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
